arp_tx_sched: RTL and testbench
===============================

// Module: arp_tx_sched
// PURPOSE
//  Sequences the ARP transmit engine: merges key-triggered requests and rx-triggered replies onto one
//  arp_tx_en/arp_tx_type command port, waits for transmit completion, times out unanswered requests,
//  retries up to a limit, and reports resolved/failed status. Sits between ARP rx/tx and user key.
// PARAMETERS
//  RETRY_CYC      125_000_000  clocks to wait for an ARP reply after a request completes (1 s @125 MHz)
//  MAX_RETRY      3            request resends after the first before declaring failure
//  TX_TIMEOUT_CYC 4096         watchdog: clocks to wait for arp_tx_done before forcing completion
// PORTS
//  clk          in  1  system clock
//  rst          in  1  synchronous reset, active-high
//  touch_key    in  1  asynchronous key level; rising edge requests an ARP request
//  arp_rx_done  in  1  one-cycle pulse: ARP frame received
//  arp_rx_type  in  1  valid with arp_rx_done; 0 request, 1 reply
//  arp_tx_done  in  1  one-cycle pulse from ARP tx engine: frame sent
//  arp_tx_en    out 1  one-cycle launch pulse to ARP tx engine
//  arp_tx_type  out 1  0 request, 1 reply; updated with arp_tx_en, held until next launch
//  arp_busy     out 1  high whenever state != IDLE
//  arp_resolved out 1  level: reply received for outstanding request
//  arp_fail     out 1  level: retries exhausted with no reply
//  retry_cnt    out $clog2(MAX_RETRY+1)  resends issued for current request
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pending flags/timers 0. rst mid-operation aborts at once; next cycle idle.
//  - touch_key: 2-FF sync + edge reg; key high first sampled at edge N -> req_pend set at N+2 -> arp_tx_en at N+3 (idle).
//  - arp_rx_done & type 0 -> rep_pend set (sticky; repeated requests merge into one reply); launch next edge if idle.
//  - States: IDLE, WAIT_DONE, WAIT_REPLY. Launch = arp_tx_en 1 cycle, latch type, clear that pending flag.
//  - IDLE: rep_pend -> launch reply; else req_pend -> launch request, set req_out, clear resolved/fail,
//    retry_cnt=0. Go WAIT_DONE. Reply always beats request in the same cycle.
//  - WAIT_DONE: arp_tx_done or watchdog reaching TX_TIMEOUT_CYC-1 -> req_out ? WAIT_REPLY : IDLE.
//    Reply timer loaded with RETRY_CYC only when a request (not a reply) completes.
//  - WAIT_REPLY: timer decrements every cycle, including while a reply is being sent.
//    arp_rx_done & type 1 -> arp_resolved=1, req_out=0, IDLE (wins over same-cycle timer expiry).
//    rep_pend -> launch reply, WAIT_DONE, return here afterwards; expiry during that saturates at 0, handled on return.
//    Timer 0 & retry_cnt<MAX_RETRY -> retry_cnt+1, relaunch request. Timer 0 & retry_cnt==MAX_RETRY ->
//    arp_fail=1, req_out=0, IDLE.
//  - Key edge while req_out=1 is dropped; reply (type 1) with req_out=0 is ignored; arp_tx_done in IDLE ignored.
//  - Counters: timer width $clog2(RETRY_CYC+1), watchdog $clog2(TX_TIMEOUT_CYC+1); no wrap, saturate at 0.
// CONFIGURATION
//  ARP_AUTO_REQ_EN defined: req_pend set on first cycle after rst deasserts (auto-resolve at power-up).
//  Not defined: requests originate from touch_key only.
// STRUCTURE
//  Package arp_pkg: state encoding (IDLE/WAIT_DONE/WAIT_REPLY), ARP_TYPE_REQ=0, ARP_TYPE_REP=1.
//  Sub-module key_edge_sync: 2-FF synchroniser + rising-edge pulse (clk, rst, din, pulse).
// TESTING (RETRY_CYC=1000, MAX_RETRY=2, TX_TIMEOUT_CYC=64)
//  1 key rise, tx_done 10 clk after launch, reply 100 clk later -> one arp_tx_en type0, arp_resolved=1, retry_cnt=0.
//  2 key rise, tx_done each time, no reply -> 3 type0 launches ~1010 clk apart, then arp_fail=1, retry_cnt=2.
//  3 rx request 300 clk into WAIT_REPLY -> type1 launch, then back to WAIT_REPLY; 1st retry still ~1000 clk after tx_done.
//  4 key-edge req_pend and rx request same cycle in IDLE -> type1 launch first, type0 launch after its tx_done.
//  5 launch with arp_tx_done never pulsed -> exit WAIT_DONE after 64 clk; arp_busy follows state.
//  6 rst asserted in WAIT_REPLY -> next cycle all outputs 0, IDLE; late reply afterwards ignored.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared definitions for the ARP transmit scheduler: FSM state encoding and
// the one-bit ARP operation codes used on the rx/tx type signals.
package arp_pkg;

    // Scheduler states
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd1;
    localparam logic [1:0] ST_WAIT_REPLY = 2'd2;

    // ARP operation codes as carried on arp_rx_type / arp_tx_type
    localparam logic ARP_TYPE_REQ = 1'b0;
    localparam logic ARP_TYPE_REP = 1'b1;

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for the asynchronous touch key followed by an edge
// register; pulse_o is high for one cycle after a synchronised rising edge.
module key_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic pulse_o
);

    // sync_q[0..1] form the synchroniser, sync_q[2] holds the previous level
    logic [2:0] sync_q;

    // Shift the key level through the synchroniser and edge register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour, giving a real shift chain.
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din_i};
        end
    end

    assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: merges key-triggered requests and rx-triggered
// replies onto one launch port, waits for tx completion (with watchdog),
// times out unanswered requests, retries, and reports resolved/failed.
// Optional feature: define ARP_AUTO_REQ_EN to queue a request on the first
// cycle after reset deasserts.
module arp_tx_sched
    import arp_pkg::*;
#(
    parameter int RETRY_CYC      = 125_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int TX_TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           touch_key_i,
    input  logic                           arp_rx_done_i,
    input  logic                           arp_rx_type_i,
    input  logic                           arp_tx_done_i,
    output logic                           arp_tx_en_o,
    output logic                           arp_tx_type_o,
    output logic                           arp_busy_o,
    output logic                           arp_resolved_o,
    output logic                           arp_fail_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

    localparam int CNT_W   = $clog2(MAX_RETRY + 1);
    localparam int TIMER_W = $clog2(RETRY_CYC + 1);
    localparam int WDOG_W  = $clog2(TX_TIMEOUT_CYC + 1);

    logic [1:0]         state_q,    state_d;
    logic               req_pend_q, req_pend_d;
    logic               rep_pend_q, rep_pend_d;
    logic               req_out_q,  req_out_d;
    logic               resolved_q, resolved_d;
    logic               fail_q,     fail_d;
    logic [CNT_W-1:0]   retry_q,    retry_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [WDOG_W-1:0]  wdog_q,     wdog_d;
    logic               tx_type_q,  tx_type_d;
    logic               tx_en_q;

    logic launch;
    logic launch_type;
    logic key_pulse;
    logic boot_req;
    logic rx_req;
    logic rx_rep;

    key_edge_sync u_key_sync (
        .clk     (clk),
        .rst     (rst),
        .din_i   (touch_key_i),
        .pulse_o (key_pulse)
    );

`ifdef ARP_AUTO_REQ_EN
    logic boot_q;

    // One-shot flag: high only for the first cycle after reset releases
    always_ff @(posedge clk) begin
        if (rst) begin
            boot_q <= 1'b1;
        end else begin
            boot_q <= 1'b0;
        end
    end

    assign boot_req = boot_q;
`else
    assign boot_req = 1'b0;
`endif

    assign rx_req = arp_rx_done_i & (arp_rx_type_i == ARP_TYPE_REQ);
    assign rx_rep = arp_rx_done_i & (arp_rx_type_i == ARP_TYPE_REP);

    // Next-state logic: launch arbitration, completion, reply timeout and retries
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        req_out_d   = req_out_q;
        resolved_d  = resolved_q;
        fail_d      = fail_q;
        retry_d     = retry_q;
        timer_d     = (timer_q != '0) ? timer_q - TIMER_W'(1) : '0;
        launch      = 1'b0;
        launch_type = ARP_TYPE_REQ;

        case (state_q)
            ST_IDLE: begin
                // A pending reply always goes out before a pending request
                if (rep_pend_q) begin
                    launch      = 1'b1;
                    launch_type = ARP_TYPE_REP;
                    state_d     = ST_WAIT_DONE;
                end else if (req_pend_q) begin
                    launch      = 1'b1;
                    launch_type = ARP_TYPE_REQ;
                    req_out_d   = 1'b1;
                    resolved_d  = 1'b0;
                    fail_d      = 1'b0;
                    retry_d     = '0;
                    state_d     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (arp_tx_done_i || (wdog_q == WDOG_W'(TX_TIMEOUT_CYC - 1))) begin
                    if (req_out_q) begin
                        state_d = ST_WAIT_REPLY;
                        // Only a finished request restarts the reply window;
                        // a reply sent mid-wait leaves the running timer alone.
                        if (tx_type_q == ARP_TYPE_REQ) begin
                            timer_d = TIMER_W'(RETRY_CYC);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_REPLY: begin
                if (rx_rep) begin
                    resolved_d = 1'b1;
                    req_out_d  = 1'b0;
                    state_d    = ST_IDLE;
                end else if (rep_pend_q) begin
                    launch      = 1'b1;
                    launch_type = ARP_TYPE_REP;
                    state_d     = ST_WAIT_DONE;
                end else if (timer_q == '0) begin
                    if (retry_q < CNT_W'(MAX_RETRY)) begin
                        retry_d     = retry_q + CNT_W'(1);
                        launch      = 1'b1;
                        launch_type = ARP_TYPE_REQ;
                        state_d     = ST_WAIT_DONE;
                    end else begin
                        fail_d    = 1'b1;
                        req_out_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pending flags: a new event in the launch cycle survives the clear
        rep_pend_d = (rep_pend_q & ~(launch & (launch_type == ARP_TYPE_REP))) | rx_req;
        req_pend_d = (req_pend_q & ~(launch & (launch_type == ARP_TYPE_REQ)))
                   | (key_pulse & ~req_out_q) | boot_req;

        // Watchdog restarts on every launch and saturates at the timeout
        if (launch) begin
            wdog_d = '0;
        end else if ((state_q == ST_WAIT_DONE) && (wdog_q != WDOG_W'(TX_TIMEOUT_CYC))) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end else begin
            wdog_d = wdog_q;
        end

        tx_type_d = launch ? launch_type : tx_type_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_pend_q <= 1'b0;
            rep_pend_q <= 1'b0;
            req_out_q  <= 1'b0;
            resolved_q <= 1'b0;
            fail_q     <= 1'b0;
            retry_q    <= '0;
            timer_q    <= '0;
            wdog_q     <= '0;
            tx_type_q  <= 1'b0;
            tx_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pend_q <= req_pend_d;
            rep_pend_q <= rep_pend_d;
            req_out_q  <= req_out_d;
            resolved_q <= resolved_d;
            fail_q     <= fail_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            wdog_q     <= wdog_d;
            tx_type_q  <= tx_type_d;
            tx_en_q    <= launch;
        end
    end

    assign arp_tx_en_o    = tx_en_q;
    assign arp_tx_type_o  = tx_type_q;
    assign arp_busy_o     = (state_q != ST_IDLE);
    assign arp_resolved_o = resolved_q;
    assign arp_fail_o     = fail_q;
    assign retry_cnt_o    = retry_q;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Self-checking bench for arp_tx_sched. Expected launches are queued when
// stimulus is issued; a monitor pops and compares on every arp_tx_en.
module tb_arp_tx_sched;

    localparam int RETRY_CYC      = 1000;
    localparam int MAX_RETRY      = 2;
    localparam int TX_TIMEOUT_CYC = 64;

    typedef struct {
        logic typ;
        bit   retry;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       touch_key;
    logic       arp_rx_done;
    logic       arp_rx_type;
    logic       arp_tx_done;
    logic       resp_done;
    logic       stray_done;
    logic       arp_tx_en;
    logic       arp_tx_type;
    logic       arp_busy;
    logic       arp_resolved;
    logic       arp_fail;
    logic [1:0] retry_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   last_req_done_cyc = 0;
    int   last_launch_cyc   = 0;
    bit   resp_en  = 1'b1;
    exp_t exp_q[$];

    assign arp_tx_done = resp_done | stray_done;

    arp_tx_sched #(
        .RETRY_CYC      (RETRY_CYC),
        .MAX_RETRY      (MAX_RETRY),
        .TX_TIMEOUT_CYC (TX_TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .touch_key_i    (touch_key),
        .arp_rx_done_i  (arp_rx_done),
        .arp_rx_type_i  (arp_rx_type),
        .arp_tx_done_i  (arp_tx_done),
        .arp_tx_en_o    (arp_tx_en),
        .arp_tx_type_o  (arp_tx_type),
        .arp_busy_o     (arp_busy),
        .arp_resolved_o (arp_resolved),
        .arp_fail_o     (arp_fail),
        .retry_cnt_o    (retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_checks++;
        if (actual >= lo && actual <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, actual, lo, hi, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every launch must match the head of the expected queue
    always @(negedge clk) begin
        if (arp_tx_en && !rst) begin
            last_launch_cyc = cyc;
            check("launch_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("launch_type", int'(arp_tx_type), int'(e.typ));
                if (e.retry)
                    check_range("retry_gap", cyc - last_req_done_cyc, RETRY_CYC, RETRY_CYC + 4);
            end
        end
    end

    // Tx engine model: answers each launch with a done pulse after a random delay
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (arp_tx_en && resp_en && !rst) begin
                logic t;
                int   d;
                t = arp_tx_type;
                d = $urandom_range(2, 20);
                repeat (d) @(posedge clk);
                #1 resp_done = 1'b1;
                if (t == 1'b0) last_req_done_cyc = cyc;
                done_cnt++;
                @(posedge clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic typ, input bit retry);
        exp_t e;
        e.typ   = typ;
        e.retry = retry;
        exp_q.push_back(e);
    endtask

    task automatic press_key(output int t0);
        touch_key = 1'b1;
        t0 = cyc;
        tick(5);
        touch_key = 1'b0;
        tick(3);
    endtask

    task automatic send_rx(input logic typ);
        arp_rx_type = typ;
        arp_rx_done = 1'b1;
        tick(1);
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            tick(1);
            n++;
        end
        check("tx_done_reached", int'(done_cnt >= target), 1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (arp_busy && n < limit) begin
            tick(1);
            n++;
        end
        check("busy_cleared", int'(arp_busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_en"},    int'(arp_tx_en), 0);
        check({tag, "_tx_type"},  int'(arp_tx_type), 0);
        check({tag, "_busy"},     int'(arp_busy), 0);
        check({tag, "_resolved"}, int'(arp_resolved), 0);
        check({tag, "_fail"},     int'(arp_fail), 0);
        check({tag, "_retry"},    int'(retry_cnt), 0);
    endtask

    // Global time limit so the run always terminates
    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int base;
        int k;
        int n;

        rst         = 1'b1;
        touch_key   = 1'b0;
        arp_rx_done = 1'b0;
        arp_rx_type = 1'b0;
        stray_done  = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(1);
        check_all_zero("reset");

        // tx_done while idle must not start anything
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        tick(2);
        check("idle_txdone_busy", int'(arp_busy), 0);

        // Randomised request scenarios: reply after launch k, or never
        for (int s = 0; s < 6; s++) begin
            k = (s < 2) ? s * (MAX_RETRY + 1) : int'($urandom_range(0, MAX_RETRY + 1));
            n = (k > MAX_RETRY) ? MAX_RETRY + 1 : k + 1;
            for (int i = 0; i < n; i++) push_exp(1'b0, i != 0);
            base = done_cnt;
            press_key(t0);
            check("key_to_launch", last_launch_cyc - t0, 4);
            if (k <= MAX_RETRY) begin
                wait_done(base + k + 1, 4000);
                tick(int'($urandom_range(50, 500)));
                send_rx(1'b1);
                wait_idle(10);
                check("resolved", int'(arp_resolved), 1);
                check("not_fail", int'(arp_fail), 0);
                check("retry_cnt_resolved", int'(retry_cnt), k);
            end else begin
                wait_idle(5000);
                check("fail", int'(arp_fail), 1);
                check("not_resolved", int'(arp_resolved), 0);
                check("retry_cnt_fail", int'(retry_cnt), MAX_RETRY);
            end
            check("queue_drained", exp_q.size(), 0);
            tick(10);
        end

        // rx request mid-wait: reply goes out, retry timing still from request done
        push_exp(1'b0, 1'b0);
        base = done_cnt;
        press_key(t0);
        wait_done(base + 1, 200);
        press_key(t0);                     // dropped: request already outstanding
        tick(300 - 8);
        push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b1);
        send_rx(1'b0);
        wait_done(base + 3, 2000);
        tick(100);
        send_rx(1'b1);
        wait_idle(10);
        check("rxreq_resolved", int'(arp_resolved), 1);
        check("rxreq_retry_cnt", int'(retry_cnt), 1);
        check("rxreq_queue", exp_q.size(), 0);
        tick(10);

        // Request and reply pending in the same idle cycle: reply first
        push_exp(1'b1, 1'b0);
        push_exp(1'b0, 1'b0);
        base = done_cnt;
        touch_key = 1'b1;
        tick(2);
        send_rx(1'b0);
        tick(3);
        touch_key = 1'b0;
        wait_done(base + 2, 200);
        tick(100);
        send_rx(1'b1);
        wait_idle(10);
        check("tie_resolved", int'(arp_resolved), 1);
        check("tie_retry_cnt", int'(retry_cnt), 0);
        check("tie_queue", exp_q.size(), 0);
        tick(10);

        // Watchdog: no tx_done, reply launch leaves WAIT_DONE after 64 cycles
        resp_en = 1'b0;
        push_exp(1'b1, 1'b0);
        send_rx(1'b0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (arp_busy) n++;
            tick(1);
        end
        check("wdog_busy_cycles", n, TX_TIMEOUT_CYC);
        check("wdog_queue", exp_q.size(), 0);
        resp_en = 1'b1;
        tick(10);

        // Reset during WAIT_REPLY aborts; late reply ignored
        push_exp(1'b0, 1'b0);
        base = done_cnt;
        press_key(t0);
        wait_done(base + 1, 200);
        tick(100);
        check("pre_rst_busy", int'(arp_busy), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all_zero("mid_rst");
        tick(5);
        send_rx(1'b1);
        tick(20);
        check("late_reply_resolved", int'(arp_resolved), 0);
        check("late_reply_busy", int'(arp_busy), 0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
